aqp_ovl_cmd: RTL and testbench



---
 rtl/aqp_ovl_cmd.sv | 193 +++++++++++++++++++
 tb/tb_aqp_ovl_cmd.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/aqp_ovl_cmd.sv
// rtl/aqp_ovl_cmd.sv - overlay command parser: byte stream to text/font/palette write strobes
// Streamed writes auto-increment their pointer; FILL replays one text word cnt times.
module aqp_ovl_cmd (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_start,
  output logic        rx_ready,
  output logic        busy,
  output logic [9:0]  ovl_text_addr,
  output logic [15:0] ovl_text_wrdata,
  output logic        ovl_text_wr,
  output logic [10:0] ovl_font_addr,
  output logic [7:0]  ovl_font_wrdata,
  output logic        ovl_font_wr,
  output logic [3:0]  ovl_palette_addr,
  output logic [15:0] ovl_palette_wrdata,
  output logic        ovl_palette_wr
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_L, S_ADDR_H, S_CNT_L, S_CNT_H,
    S_DATA_L, S_DATA_H, S_FILL, S_DISCARD
  } state_t;

  typedef enum logic [1:0] {C_TEXT, C_FONT, C_PAL, C_FILL} cmd_t;

  state_t      state, state_nxt;
  cmd_t        cmd, cmd_nxt;
  logic [10:0] ptr, ptr_nxt;
  logic [9:0]  cnt, cnt_nxt;
  logic [7:0]  lo, lo_nxt;
  logic [15:0] fill_data, fill_data_nxt;

  logic [9:0]  text_addr_nxt;
  logic [15:0] text_data_nxt;
  logic        text_wr_nxt;
  logic [10:0] font_addr_nxt;
  logic [7:0]  font_data_nxt;
  logic        font_wr_nxt;
  logic [3:0]  pal_addr_nxt;
  logic [15:0] pal_data_nxt;
  logic        pal_wr_nxt;

  logic        acc;
  logic [10:0] text_inc, font_inc, pal_inc;

  assign rx_ready = (state != S_FILL);
  assign busy     = (state == S_FILL);
  assign acc      = rx_valid && rx_ready;

  // Each target wraps at its own RAM depth
  assign text_inc = {1'b0, ptr[9:0] + 10'd1};
  assign font_inc = ptr + 11'd1;
  assign pal_inc  = {7'd0, ptr[3:0] + 4'd1};

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= S_IDLE;
      cmd                <= C_TEXT;
      ptr                <= '0;
      cnt                <= '0;
      lo                 <= '0;
      fill_data          <= '0;
      ovl_text_addr      <= '0;
      ovl_text_wrdata    <= '0;
      ovl_text_wr        <= 1'b0;
      ovl_font_addr      <= '0;
      ovl_font_wrdata    <= '0;
      ovl_font_wr        <= 1'b0;
      ovl_palette_addr   <= '0;
      ovl_palette_wrdata <= '0;
      ovl_palette_wr     <= 1'b0;
    end else begin
      state              <= state_nxt;
      cmd                <= cmd_nxt;
      ptr                <= ptr_nxt;
      cnt                <= cnt_nxt;
      lo                 <= lo_nxt;
      fill_data          <= fill_data_nxt;
      ovl_text_addr      <= text_addr_nxt;
      ovl_text_wrdata    <= text_data_nxt;
      ovl_text_wr        <= text_wr_nxt;
      ovl_font_addr      <= font_addr_nxt;
      ovl_font_wrdata    <= font_data_nxt;
      ovl_font_wr        <= font_wr_nxt;
      ovl_palette_addr   <= pal_addr_nxt;
      ovl_palette_wrdata <= pal_data_nxt;
      ovl_palette_wr     <= pal_wr_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cmd_nxt       = cmd;
    ptr_nxt       = ptr;
    cnt_nxt       = cnt;
    lo_nxt        = lo;
    fill_data_nxt = fill_data;
    text_addr_nxt = ovl_text_addr;
    text_data_nxt = ovl_text_wrdata;
    text_wr_nxt   = 1'b0;
    font_addr_nxt = ovl_font_addr;
    font_data_nxt = ovl_font_wrdata;
    font_wr_nxt   = 1'b0;
    pal_addr_nxt  = ovl_palette_addr;
    pal_data_nxt  = ovl_palette_wrdata;
    pal_wr_nxt    = 1'b0;

    if (state == S_FILL) begin
      text_wr_nxt   = 1'b1;
      text_addr_nxt = ptr[9:0];
      text_data_nxt = fill_data;
      ptr_nxt       = text_inc;
      cnt_nxt       = cnt - 10'd1;
      if (cnt == 10'd1)
        state_nxt = S_IDLE;
    end else if (acc && rx_start) begin
      // A command byte always restarts; any half-assembled word is dropped
      state_nxt = S_ADDR_L;
      case (rx_data)
        8'h01:   cmd_nxt = C_TEXT;
        8'h02:   cmd_nxt = C_FONT;
        8'h03:   cmd_nxt = C_PAL;
        8'h04:   cmd_nxt = C_FILL;
        default: state_nxt = S_DISCARD;
      endcase
    end else if (acc) begin
      case (state)
        S_ADDR_L: begin
          if (cmd == C_PAL) begin
            ptr_nxt   = {7'd0, rx_data[3:0]};
            state_nxt = S_DATA_L;
          end else begin
            ptr_nxt   = {3'd0, rx_data};
            state_nxt = S_ADDR_H;
          end
        end
        S_ADDR_H: begin
          if (cmd == C_FONT)
            ptr_nxt = {rx_data[2:0], ptr[7:0]};
          else
            ptr_nxt = {1'b0, rx_data[1:0], ptr[7:0]};
          state_nxt = (cmd == C_FILL) ? S_CNT_L : S_DATA_L;
        end
        S_CNT_L: begin
          cnt_nxt   = {2'd0, rx_data};
          state_nxt = S_CNT_H;
        end
        S_CNT_H: begin
          cnt_nxt   = {rx_data[1:0], cnt[7:0]};
          state_nxt = S_DATA_L;
        end
        S_DATA_L: begin
          if (cmd == C_FONT) begin
            font_wr_nxt   = 1'b1;
            font_addr_nxt = ptr;
            font_data_nxt = rx_data;
            ptr_nxt       = font_inc;
          end else begin
            lo_nxt    = rx_data;
            state_nxt = S_DATA_H;
          end
        end
        S_DATA_H: begin
          state_nxt = S_DATA_L;
          case (cmd)
            C_TEXT: begin
              text_wr_nxt   = 1'b1;
              text_addr_nxt = ptr[9:0];
              text_data_nxt = {rx_data, lo};
              ptr_nxt       = text_inc;
            end
            C_PAL: begin
              pal_wr_nxt   = 1'b1;
              pal_addr_nxt = ptr[3:0];
              pal_data_nxt = {rx_data, lo};
              ptr_nxt      = pal_inc;
            end
            C_FILL: begin
              fill_data_nxt = {rx_data, lo};
              state_nxt     = (cnt == 10'd0) ? S_IDLE : S_FILL;
            end
            default: state_nxt = S_DATA_L;
          endcase
        end
        default: state_nxt = state;
      endcase
    end
  end

endmodule

// File: tb/tb_aqp_ovl_cmd.sv
// tb/tb_aqp_ovl_cmd.sv - directed self-checking bench for aqp_ovl_cmd
module tb_aqp_ovl_cmd;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_start;
  logic        rx_ready;
  logic        busy;
  logic [9:0]  ovl_text_addr;
  logic [15:0] ovl_text_wrdata;
  logic        ovl_text_wr;
  logic [10:0] ovl_font_addr;
  logic [7:0]  ovl_font_wrdata;
  logic        ovl_font_wr;
  logic [3:0]  ovl_palette_addr;
  logic [15:0] ovl_palette_wrdata;
  logic        ovl_palette_wr;

  aqp_ovl_cmd dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_start(rx_start),
    .rx_ready(rx_ready), .busy(busy),
    .ovl_text_addr(ovl_text_addr), .ovl_text_wrdata(ovl_text_wrdata), .ovl_text_wr(ovl_text_wr),
    .ovl_font_addr(ovl_font_addr), .ovl_font_wrdata(ovl_font_wrdata), .ovl_font_wr(ovl_font_wr),
    .ovl_palette_addr(ovl_palette_addr), .ovl_palette_wrdata(ovl_palette_wrdata),
    .ovl_palette_wr(ovl_palette_wr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int t_addr[$], t_data[$], t_cyc[$];
  int f_addr[$], f_data[$], f_cyc[$];
  int p_addr[$], p_data[$];
  int ready_low = 0;
  int multi_wr = 0;

  always @(negedge clk) begin
    if (ovl_text_wr) begin
      t_addr.push_back(int'(ovl_text_addr));
      t_data.push_back(int'(ovl_text_wrdata));
      t_cyc.push_back(cyc);
    end
    if (ovl_font_wr) begin
      f_addr.push_back(int'(ovl_font_addr));
      f_data.push_back(int'(ovl_font_wrdata));
      f_cyc.push_back(cyc);
    end
    if (ovl_palette_wr) begin
      p_addr.push_back(int'(ovl_palette_addr));
      p_data.push_back(int'(ovl_palette_wrdata));
    end
    if (!rx_ready) ready_low++;
    if ((int'(ovl_text_wr) + int'(ovl_font_wr) + int'(ovl_palette_wr)) > 1) multi_wr++;
  end

  int n_total = 0;
  int n_pass  = 0;
  int acc_cyc = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_logs();
    t_addr.delete(); t_data.delete(); t_cyc.delete();
    f_addr.delete(); f_data.delete(); f_cyc.delete();
    p_addr.delete(); p_data.delete();
    ready_low = 0;
  endtask

  task automatic send(input logic [7:0] b, input logic st);
    int n;
    rx_data  = b;
    rx_start = st;
    rx_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rx_ready && n < 2000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 2000) chk("send_timeout", n, 0);
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    rx_valid = 1'b0;
    rx_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int a_fill;
    reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", int'(rx_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wr", int'({ovl_text_wr, ovl_font_wr, ovl_palette_wr}), 0);
    chk("rst_taddr", int'(ovl_text_addr), 0);
    chk("rst_tdata", int'(ovl_text_wrdata), 0);
    chk("rst_faddr", int'(ovl_font_addr), 0);
    chk("rst_fdata", int'(ovl_font_wrdata), 0);
    chk("rst_paddr", int'(ovl_palette_addr), 0);
    chk("rst_pdata", int'(ovl_palette_wrdata), 0);
    #1;

    // TEXT at 0x3FE
    clear_logs();
    send(8'h01, 1); send(8'hFE, 0); send(8'h03, 0); send(8'h41, 0); send(8'h1F, 0);
    send(8'h42, 0);
    send(8'h2F, 0);
    idle(3);
    chk("text_n", t_addr.size(), 2);
    chk("text_a0", t_addr[0], 'h3FE);
    chk("text_d0", t_data[0], 'h1F41);
    chk("text_a1", t_addr[1], 'h3FF);
    chk("text_d1", t_data[1], 'h2F42);
    chk("text_lat", t_cyc[1], acc_cyc);

    // FONT wrap 0x7FF -> 0x000
    clear_logs();
    send(8'h02, 1); send(8'hFF, 0); send(8'h07, 0);
    send(8'hAA, 0); send(8'h55, 0); send(8'h0F, 0);
    idle(3);
    chk("font_n", f_addr.size(), 3);
    chk("font_a0", f_addr[0], 'h7FF);
    chk("font_d0", f_data[0], 'hAA);
    chk("font_a1", f_addr[1], 'h000);
    chk("font_d1", f_data[1], 'h55);
    chk("font_a2", f_addr[2], 'h001);
    chk("font_d2", f_data[2], 'h0F);
    chk("font_b2b", f_cyc[2] - f_cyc[0], 2);
    chk("font_lat", f_cyc[2], acc_cyc);

    // PAL wrap 0xF -> 0x0
    clear_logs();
    send(8'h03, 1); send(8'h0F, 0);
    send(8'h00, 0); send(8'h8F, 0); send(8'h23, 0); send(8'h01, 0);
    idle(3);
    chk("pal_n", p_addr.size(), 2);
    chk("pal_a0", p_addr[0], 'hF);
    chk("pal_d0", p_data[0], 'h8F00);
    chk("pal_a1", p_addr[1], 'h0);
    chk("pal_d1", p_data[1], 'h0123);

    // FILL cnt 3
    clear_logs();
    send(8'h04, 1); send(8'h10, 0); send(8'h00, 0); send(8'h03, 0); send(8'h00, 0);
    send(8'h20, 0);
    send(8'h70, 0);
    a_fill = acc_cyc;
    @(negedge clk);
    chk("fill_busy", int'(busy), 1);
    idle(6);
    chk("fill_n", t_addr.size(), 3);
    chk("fill_a0", t_addr[0], 'h010);
    chk("fill_a2", t_addr[2], 'h012);
    chk("fill_d1", t_data[1], 'h7020);
    chk("fill_d2", t_data[2], 'h7020);
    chk("fill_first", t_cyc[0], a_fill + 1);
    chk("fill_last", t_cyc[2], a_fill + 3);
    chk("fill_ready_low", ready_low, 3);

    // FILL cnt 0
    clear_logs();
    send(8'h04, 1); send(8'h10, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    send(8'h20, 0); send(8'h70, 0);
    idle(4);
    chk("fill0_n", t_addr.size(), 0);
    chk("fill0_ready_low", ready_low, 0);

    // Unknown command abandons a pending low byte and discards until next start
    clear_logs();
    send(8'h01, 1); send(8'h00, 0); send(8'h00, 0); send(8'h41, 0);
    send(8'h09, 1); send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    idle(3);
    chk("disc_writes", t_addr.size() + f_addr.size() + p_addr.size(), 0);
    chk("disc_ready_low", ready_low, 0);
    send(8'h01, 1); send(8'h05, 0); send(8'h00, 0); send(8'h34, 0); send(8'h12, 0);
    idle(3);
    chk("disc_text_n", t_addr.size(), 1);
    chk("disc_text_a", t_addr[0], 'h005);
    chk("disc_text_d", t_data[0], 'h1234);

    // Reset during a cnt=10 fill
    clear_logs();
    send(8'h04, 1); send(8'h00, 0); send(8'h00, 0); send(8'h0A, 0); send(8'h00, 0);
    send(8'h41, 0); send(8'h07, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rstf_busy_before", int'(busy), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstf_wr", int'(ovl_text_wr), 0);
    chk("rstf_addr", int'(ovl_text_addr), 0);
    chk("rstf_data", int'(ovl_text_wrdata), 0);
    chk("rstf_ready", int'(rx_ready), 1);
    chk("rstf_busy", int'(busy), 0);
    #1;
    idle(3);
    chk("rstf_n", t_addr.size(), 1);
    send(8'h01, 1); send(8'h07, 0); send(8'h00, 0); send(8'h55, 0); send(8'h66, 0);
    idle(3);
    chk("rstf_text_n", t_addr.size(), 2);
    chk("rstf_text_a", t_addr[1], 'h007);
    chk("rstf_text_d", t_data[1], 'h6655);

    chk("one_strobe", multi_wr, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
